// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus between the decode/execute datapath and pipe_ctrl.
// The datapath side uses the master modport; the hazard controller uses the slave modport.
interface pipe_ctrl_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] instr_decode;
    logic [4:0]      rd_addr_exe;
    logic            mem_read_exe;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            br_true;
    logic [XLEN-1:0] br_decode;
    logic [XLEN-1:0] jal_decode;
    logic [XLEN-1:0] jalr_decode;
    logic            mc_start;
    logic            mc_done;

    logic            stall_if;
    logic            stall_id;
    logic            flush_id;
    logic            flush_if;
    logic            redirect;
    logic [XLEN-1:0] pc_target;
    logic [1:0]      state;
    logic            mc_err;
    logic [31:0]     stall_cnt;

    modport master (
        output instr_decode, rd_addr_exe, mem_read_exe, is_branch, is_jal, is_jalr,
               br_true, br_decode, jal_decode, jalr_decode, mc_start, mc_done,
        input  stall_if, stall_id, flush_id, flush_if, redirect, pc_target,
               state, mc_err, stall_cnt
    );

    modport slave (
        input  instr_decode, rd_addr_exe, mem_read_exe, is_branch, is_jal, is_jalr,
               br_true, br_decode, jal_decode, jalr_decode, mc_start, mc_done,
        output stall_if, stall_id, flush_id, flush_if, redirect, pc_target,
               state, mc_err, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle unit waits with timeout,
// and control-transfer redirects resolved in ID.
module pipe_ctrl #(
    parameter int XLEN           = 32,
    parameter int LOAD_STALL_CYC = 1,
    parameter int MC_TIMEOUT     = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MC_WAIT  = 2'd2,
        ERR      = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      bub_q, bub_d;
    logic [7:0]      to_q, to_d;
    logic            err_q, err_d;
    logic [31:0]     cnt_q;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            hazard;
    logic            stall;
    logic            redir;
    logic [XLEN-1:0] target;
    logic            unused_instr_bits;

    assign rs1 = bus.instr_decode[19:15];
    assign rs2 = bus.instr_decode[24:20];
    assign unused_instr_bits = ^{bus.instr_decode[XLEN-1:25], bus.instr_decode[14:0]};

    assign hazard = bus.mem_read_exe && (bus.rd_addr_exe != 5'd0) &&
                    ((bus.rd_addr_exe == rs1) || (bus.rd_addr_exe == rs2));

    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        to_d    = to_q;
        err_d   = err_q;
        stall   = 1'b0;
        redir   = 1'b0;
        target  = '0;
        case (state_q)
            RUN: begin
                // mc_start outranks a load-use hazard, which in turn blocks any redirect
                if (bus.mc_start) begin
                    stall   = 1'b1;
                    to_d    = 8'd0;
                    state_d = MC_WAIT;
                end else if (hazard) begin
                    stall = 1'b1;
                    bub_d = 3'(LOAD_STALL_CYC - 1);
                    if (LOAD_STALL_CYC > 1) begin
                        state_d = LD_STALL;
                    end
                end else if (bus.is_jal) begin
                    redir  = 1'b1;
                    target = bus.jal_decode;
                end else if (bus.is_jalr) begin
                    redir  = 1'b1;
                    target = bus.jalr_decode;
                end else if (bus.is_branch && bus.br_true) begin
                    redir  = 1'b1;
                    target = bus.br_decode;
                end
            end
            LD_STALL: begin
                stall = 1'b1;
                bub_d = bub_q - 3'd1;
                if (bub_q == 3'd1) begin
                    state_d = RUN;
                end
            end
            MC_WAIT: begin
                stall = 1'b1;
                if (bus.mc_done) begin
                    to_d    = 8'd0;
                    state_d = RUN;
                end else begin
                    to_d = to_q + 8'd1;
                    if (to_q == 8'(MC_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            default: begin
                stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            bub_q   <= 3'd0;
            to_q    <= 8'd0;
            err_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            to_q    <= to_d;
            err_q   <= err_d;
            if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // Controls are masked by rst_n so they drop the moment reset asserts, not at the next edge
    assign bus.stall_if  = stall & rst_n;
    assign bus.stall_id  = stall & rst_n;
    assign bus.flush_id  = stall & rst_n;
    assign bus.flush_if  = redir & rst_n;
    assign bus.redirect  = redir & rst_n;
    assign bus.pc_target = rst_n ? target : '0;
    assign bus.state     = state_q;
    assign bus.mc_err    = err_q;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for RUN-state decisions plus hand-written
// sequences for load-use bubbles, multi-cycle waits, timeout and asynchronous reset.
module tb_pipe_ctrl;
    localparam int XLEN = 32;
    localparam logic [31:0] BR_T   = 32'h0000_0100;
    localparam logic [31:0] JAL_T  = 32'h0000_0200;
    localparam logic [31:0] JALR_T = 32'h0000_1000;
    localparam int NV = 10;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mem_read;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       br_true;
        logic       mc_start;
        logic       mc_done;
    } in_t;

    typedef struct {
        in_t         stim;
        logic        stall;
        logic        redir;
        logic [31:0] target;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    pipe_ctrl_if #(.XLEN(XLEN)) bus ();
    pipe_ctrl_if #(.XLEN(XLEN)) bus3 ();

    pipe_ctrl #(.XLEN(XLEN), .LOAD_STALL_CYC(1), .MC_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    pipe_ctrl #(.XLEN(XLEN), .LOAD_STALL_CYC(3), .MC_TIMEOUT(64)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    function automatic in_t mkIn(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic mem, input logic br,
                                 input logic jal, input logic jalr, input logic brt);
        in_t s;
        s = '0;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.mem_read = mem;
        s.is_branch = br; s.is_jal = jal; s.is_jalr = jalr; s.br_true = brt;
        return s;
    endfunction

    function automatic vec_t mkVec(input in_t s, input logic stall, input logic redir,
                                   input logic [31:0] target);
        vec_t v;
        v.stim = s; v.stall = stall; v.redir = redir; v.target = target;
        return v;
    endfunction

    task automatic applyStimulus(input in_t s, input bit alt = 1'b0);
        if (!alt) begin
            bus.instr_decode = {7'h00, s.rs2, s.rs1, 15'h0013};
            bus.rd_addr_exe  = s.rd;
            bus.mem_read_exe = s.mem_read;
            bus.is_branch    = s.is_branch;
            bus.is_jal       = s.is_jal;
            bus.is_jalr      = s.is_jalr;
            bus.br_true      = s.br_true;
            bus.mc_start     = s.mc_start;
            bus.mc_done      = s.mc_done;
            bus.br_decode    = BR_T;
            bus.jal_decode   = JAL_T;
            bus.jalr_decode  = JALR_T;
        end else begin
            bus3.instr_decode = {7'h00, s.rs2, s.rs1, 15'h0013};
            bus3.rd_addr_exe  = s.rd;
            bus3.mem_read_exe = s.mem_read;
            bus3.is_branch    = s.is_branch;
            bus3.is_jal       = s.is_jal;
            bus3.is_jalr      = s.is_jalr;
            bus3.br_true      = s.br_true;
            bus3.mc_start     = s.mc_start;
            bus3.mc_done      = s.mc_done;
            bus3.br_decode    = BR_T;
            bus3.jal_decode   = JAL_T;
            bus3.jalr_decode  = JALR_T;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkCtrl(input string tag, input logic stall, input logic redir,
                             input logic [31:0] target);
        checkOutput({tag, " stall_if"}, 32'(bus.stall_if), 32'(stall));
        checkOutput({tag, " stall_id"}, 32'(bus.stall_id), 32'(stall));
        checkOutput({tag, " flush_id"}, 32'(bus.flush_id), 32'(stall));
        checkOutput({tag, " flush_if"}, 32'(bus.flush_if), 32'(redir));
        checkOutput({tag, " redirect"}, 32'(bus.redirect), 32'(redir));
        checkOutput({tag, " pc_target"}, bus.pc_target, target);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus('0);
        applyStimulus('0, 1'b1);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        in_t s;
        int  exp_cnt;

        vecs[0] = mkVec(mkIn(5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 32'h0);
        vecs[1] = mkVec(mkIn(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 32'h0);
        vecs[2] = mkVec(mkIn(5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 32'h0);
        vecs[3] = mkVec(mkIn(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 32'h0);
        vecs[4] = mkVec(mkIn(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 32'h0);
        vecs[5] = mkVec(mkIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, JAL_T);
        vecs[6] = mkVec(mkIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, 1'b1, JALR_T);
        vecs[7] = mkVec(mkIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0, 1'b1, BR_T);
        vecs[8] = mkVec(mkIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 32'h0);
        vecs[9] = mkVec(mkIn(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 32'h0);

        // Reset with provocative inputs: every control must still read zero
        rst_n = 1'b0;
        s = mkIn(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        s.mc_start = 1'b1;
        applyStimulus(s);
        applyStimulus('0, 1'b1);
        #3;
        checkCtrl("reset", 1'b0, 1'b0, 32'h0);
        checkOutput("reset state", 32'(bus.state), 32'd0);
        checkOutput("reset mc_err", 32'(bus.mc_err), 32'd0);
        checkOutput("reset stall_cnt", bus.stall_cnt, 32'd0);
        applyStimulus('0);
        @(negedge clk);
        rst_n = 1'b1;

        exp_cnt = 0;
        for (int i = 0; i < NV; i++) begin
            nextCycle();
            applyStimulus(vecs[i].stim);
            #1;
            checkCtrl($sformatf("vec%0d", i), vecs[i].stall, vecs[i].redir, vecs[i].target);
            if (vecs[i].stall) exp_cnt++;
        end
        nextCycle();
        applyStimulus('0);
        #1;
        checkOutput("table stall_cnt", bus.stall_cnt, 32'(exp_cnt));
        checkOutput("table state", 32'(bus.state), 32'd0);

        // Single-bubble load-use, then the bubble sits in EXE
        resetPulse();
        nextCycle();
        applyStimulus(mkIn(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        #1;
        checkCtrl("ld1 hazard", 1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus('0);
        #1;
        checkCtrl("ld1 after", 1'b0, 1'b0, 32'h0);
        checkOutput("ld1 stall_cnt", bus.stall_cnt, 32'd1);
        checkOutput("ld1 state", 32'(bus.state), 32'd0);

        // Hazard and taken branch together: redirect deferred one cycle
        nextCycle();
        applyStimulus(mkIn(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        #1;
        checkCtrl("ldbr stall", 1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(mkIn(5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        #1;
        checkCtrl("ldbr redirect", 1'b0, 1'b1, BR_T);

        // mc_done in RUN has no effect
        nextCycle();
        s = '0;
        s.mc_done = 1'b1;
        applyStimulus(s);
        #1;
        checkCtrl("done in run", 1'b0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus('0);
        #1;
        checkOutput("done in run state", 32'(bus.state), 32'd0);

        // Multi-cycle op finishing on the 10th wait cycle: 11 stalled cycles
        resetPulse();
        nextCycle();
        s = '0;
        s.mc_start = 1'b1;
        applyStimulus(s);
        #1;
        checkCtrl("mc issue", 1'b1, 1'b0, 32'h0);
        for (int i = 1; i <= 10; i++) begin
            nextCycle();
            s = mkIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            s.mc_start = 1'b1;
            s.mc_done = (i == 10);
            applyStimulus(s);
            #1;
            checkOutput($sformatf("mc wait%0d state", i), 32'(bus.state), 32'd2);
            checkOutput($sformatf("mc wait%0d stall_if", i), 32'(bus.stall_if), 32'd1);
            checkOutput($sformatf("mc wait%0d redirect", i), 32'(bus.redirect), 32'd0);
        end
        nextCycle();
        applyStimulus('0);
        #1;
        checkOutput("mc done state", 32'(bus.state), 32'd0);
        checkCtrl("mc done", 1'b0, 1'b0, 32'h0);
        checkOutput("mc stall_cnt", bus.stall_cnt, 32'd11);

        // No mc_done: 64 wait cycles, then ERR which ignores everything
        nextCycle();
        s = '0;
        s.mc_start = 1'b1;
        applyStimulus(s);
        for (int i = 1; i <= 64; i++) begin
            nextCycle();
            applyStimulus('0);
            #1;
            if (i == 1 || i == 64) begin
                checkOutput($sformatf("to wait%0d state", i), 32'(bus.state), 32'd2);
                checkOutput($sformatf("to wait%0d mc_err", i), 32'(bus.mc_err), 32'd0);
            end
        end
        nextCycle();
        s = '0;
        s.mc_done = 1'b1;
        applyStimulus(s);
        #1;
        checkOutput("err state", 32'(bus.state), 32'd3);
        checkOutput("err mc_err", 32'(bus.mc_err), 32'd1);
        checkCtrl("err", 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            s = mkIn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            s.mc_start = 1'b1;
            s.mc_done = 1'b1;
            applyStimulus(s);
        end
        #1;
        checkOutput("err sticky state", 32'(bus.state), 32'd3);
        checkCtrl("err sticky", 1'b1, 1'b0, 32'h0);

        // Three-bubble load-use on the second instance; mc_start during LD_STALL is ignored
        resetPulse();
        nextCycle();
        applyStimulus(mkIn(5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        #1;
        checkOutput("ld3 c0 stall_if", 32'(bus3.stall_if), 32'd1);
        checkOutput("ld3 c0 state", 32'(bus3.state), 32'd0);
        for (int i = 1; i <= 2; i++) begin
            nextCycle();
            s = '0;
            s.mc_start = 1'b1;
            applyStimulus(s, 1'b1);
            #1;
            checkOutput($sformatf("ld3 c%0d stall_if", i), 32'(bus3.stall_if), 32'd1);
            checkOutput($sformatf("ld3 c%0d state", i), 32'(bus3.state), 32'd1);
        end
        nextCycle();
        applyStimulus('0, 1'b1);
        #1;
        checkOutput("ld3 end stall_if", 32'(bus3.stall_if), 32'd0);
        checkOutput("ld3 end state", 32'(bus3.state), 32'd0);
        checkOutput("ld3 stall_cnt", bus3.stall_cnt, 32'd3);

        // Asynchronous reset in the middle of MC_WAIT
        resetPulse();
        nextCycle();
        s = '0;
        s.mc_start = 1'b1;
        applyStimulus(s);
        nextCycle();
        applyStimulus('0);
        #1;
        checkOutput("arst pre state", 32'(bus.state), 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("arst state", 32'(bus.state), 32'd0);
        checkOutput("arst stall_if", 32'(bus.stall_if), 32'd0);
        checkOutput("arst flush_id", 32'(bus.flush_id), 32'd0);
        checkOutput("arst stall_cnt", bus.stall_cnt, 32'd0);
        #1;
        rst_n = 1'b1;
        nextCycle();
        #1;
        checkCtrl("arst after", 1'b0, 1'b0, 32'h0);
        checkOutput("arst after state", 32'(bus.state), 32'd0);
        nextCycle();
        #1;
        checkOutput("arst after2 stall_if", 32'(bus.stall_if), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
